// File: rtl/spi_display_rx_if.sv
// SPI display receiver bus: the serial-side inputs and the decoded
// command/window/pixel outputs, grouped with master/slave views.
interface spi_display_rx_if;
  logic        i_sclk;
  logic        i_mosi;
  logic        i_dc;
  logic        i_cs;
  logic        o_cmd_valid;
  logic [7:0]  o_cmd;
  logic [15:0] o_xs;
  logic [15:0] o_xe;
  logic [15:0] o_ys;
  logic [15:0] o_ye;
  logic        o_pix_valid;
  logic [15:0] o_pix_x;
  logic [15:0] o_pix_y;
  logic [15:0] o_pix_data;
  logic        o_frame_done;
  logic        o_err;

  modport slave (
    input  i_sclk, i_mosi, i_dc, i_cs,
    output o_cmd_valid, o_cmd, o_xs, o_xe, o_ys, o_ye,
           o_pix_valid, o_pix_x, o_pix_y, o_pix_data, o_frame_done, o_err
  );

  modport master (
    output i_sclk, i_mosi, i_dc, i_cs,
    input  o_cmd_valid, o_cmd, o_xs, o_xe, o_ys, o_ye,
           o_pix_valid, o_pix_x, o_pix_y, o_pix_data, o_frame_done, o_err
  );
endinterface

// File: rtl/spi_display_rx.sv
// SPI display-controller receiver: oversampled SPI byte capture feeding a
// CASET/PASET/RAMWR parser. Define DISP_RX_BOUNDS_CHECK_EN for the sticky window error flag.
module spi_display_rx #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320
) (
  input  logic              i_clk,
  input  logic              i_rst,
  spi_display_rx_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CASET, PASET, RAMWR} state_t;

  typedef struct packed {
    state_t      state;
    logic [2:0]  arg_cnt;
    logic [23:0] args;
    logic [15:0] xs, xe, ys, ye;
    logic [15:0] cur_x, cur_y;
    logic [7:0]  hi;
    logic        phase;
    logic [7:0]  cmd;
    logic        cmd_valid;
    logic        pix_valid;
    logic [15:0] pix_x, pix_y, pix_data;
    logic        frame_done;
  } ctx_t;

  localparam logic [15:0] XE_RST = 16'(WIDTH - 1);
  localparam logic [15:0] YE_RST = 16'(HEIGHT - 1);
  localparam ctx_t CTX_RST = '{
    state: IDLE, arg_cnt: 3'd0, args: 24'd0,
    xs: 16'd0, xe: XE_RST, ys: 16'd0, ye: YE_RST,
    cur_x: 16'd0, cur_y: 16'd0, hi: 8'd0, phase: 1'b0,
    cmd: 8'd0, cmd_valid: 1'b0, pix_valid: 1'b0,
    pix_x: 16'd0, pix_y: 16'd0, pix_data: 16'd0, frame_done: 1'b0
  };

  logic [1:0] sclk_sync, mosi_sync, dc_sync, cs_sync;
  logic       sclk_prev;
  logic       sclk_rise;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      dc_sync   <= 2'b00;
      cs_sync   <= 2'b11;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], bus.i_sclk};
      mosi_sync <= {mosi_sync[0], bus.i_mosi};
      dc_sync   <= {dc_sync[0], bus.i_dc};
      cs_sync   <= {cs_sync[0], bus.i_cs};
      sclk_prev <= sclk_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_prev;

  logic [6:0] shift;
  logic [2:0] bit_cnt;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       rx_dc;

  // A deselect clears only the bit count; stale shift bits are pushed out by the next byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shift      <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      rx_dc      <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_sync[1]) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift   <= {shift[5:0], mosi_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          rx_byte    <= {shift, mosi_sync[1]};
          rx_dc      <= dc_sync[1];
        end
      end
    end
  end

  ctx_t        ctx_q, nxt;
  logic [15:0] win_lo, win_hi;

  assign win_lo = ctx_q.args[23:8];
  assign win_hi = {ctx_q.args[7:0], rx_byte};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ctx_q <= CTX_RST;
    else       ctx_q <= nxt;
  end

  // NOTE: nxt takes the held value first, so branches that skip a field cannot infer a latch.
  always_comb begin
    nxt            = ctx_q;
    nxt.cmd_valid  = 1'b0;
    nxt.pix_valid  = 1'b0;
    nxt.frame_done = 1'b0;
    if (byte_valid) begin
      if (!rx_dc) begin
        nxt.cmd       = rx_byte;
        nxt.cmd_valid = 1'b1;
        nxt.arg_cnt   = 3'd0;
        nxt.phase     = 1'b0;
        case (rx_byte)
          8'h2A:   nxt.state = CASET;
          8'h2B:   nxt.state = PASET;
          8'h2C: begin
            nxt.state = RAMWR;
            nxt.cur_x = ctx_q.xs;
            nxt.cur_y = ctx_q.ys;
          end
          default: nxt.state = IDLE;
        endcase
      end else begin
        case (ctx_q.state)
          CASET, PASET: begin
            // arg_cnt saturates at 4 so bytes after the fourth are dropped
            if (ctx_q.arg_cnt != 3'd4) begin
              nxt.args    = {ctx_q.args[15:0], rx_byte};
              nxt.arg_cnt = ctx_q.arg_cnt + 3'd1;
              if (ctx_q.arg_cnt == 3'd3) begin
                if (ctx_q.state == CASET) begin
                  nxt.xs = win_lo;
                  nxt.xe = win_hi;
                end else begin
                  nxt.ys = win_lo;
                  nxt.ye = win_hi;
                end
              end
            end
          end
          RAMWR: begin
            if (!ctx_q.phase) begin
              nxt.hi    = rx_byte;
              nxt.phase = 1'b1;
            end else begin
              nxt.phase     = 1'b0;
              nxt.pix_valid = 1'b1;
              nxt.pix_x     = ctx_q.cur_x;
              nxt.pix_y     = ctx_q.cur_y;
              nxt.pix_data  = {ctx_q.hi, rx_byte};
              if (ctx_q.cur_x == ctx_q.xe) begin
                nxt.cur_x = ctx_q.xs;
                if (ctx_q.cur_y == ctx_q.ye) begin
                  nxt.frame_done = 1'b1;
                  nxt.cur_y      = ctx_q.ys;
                end else begin
                  nxt.cur_y = ctx_q.cur_y + 16'd1;
                end
              end else begin
                nxt.cur_x = ctx_q.cur_x + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_cmd_valid  = ctx_q.cmd_valid;
  assign bus.o_cmd        = ctx_q.cmd;
  assign bus.o_xs         = ctx_q.xs;
  assign bus.o_xe         = ctx_q.xe;
  assign bus.o_ys         = ctx_q.ys;
  assign bus.o_ye         = ctx_q.ye;
  assign bus.o_pix_valid  = ctx_q.pix_valid;
  assign bus.o_pix_x      = ctx_q.pix_x;
  assign bus.o_pix_y      = ctx_q.pix_y;
  assign bus.o_pix_data   = ctx_q.pix_data;
  assign bus.o_frame_done = ctx_q.frame_done;

`ifdef DISP_RX_BOUNDS_CHECK_EN
  localparam logic [16:0] W_LIM = 17'(WIDTH);
  localparam logic [16:0] H_LIM = 17'(HEIGHT);

  logic err_q;
  logic bad_win;

  always_comb begin
    bad_win = 1'b0;
    if (byte_valid && rx_dc && ctx_q.arg_cnt == 3'd3 &&
        (ctx_q.state == CASET || ctx_q.state == PASET)) begin
      bad_win = (win_lo > win_hi) ||
                ({1'b0, win_hi} >= ((ctx_q.state == CASET) ? W_LIM : H_LIM));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        err_q <= 1'b0;
    else if (bad_win) err_q <= 1'b1;
  end

  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_display_rx.sv
// Directed bench for spi_display_rx: bit-banged SPI bytes, pulse monitors and
// hand-computed expectations for window commit, pixel walk, deselect and reset.
module tb_spi_display_rx;

  logic i_clk;
  logic i_rst;
  spi_display_rx_if bus();

  spi_display_rx #(.WIDTH(240), .HEIGHT(320)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

`ifdef DISP_RX_BOUNDS_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] d;
    logic        fd;
  } pix_t;

  pix_t pq[$];
  int   cyc = 0;
  int   cmd_cnt = 0;
  int   cmd_cyc = 0;
  int   rise_cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (bus.o_cmd_valid === 1'b1) begin
      cmd_cnt = cmd_cnt + 1;
      cmd_cyc = cyc;
    end
    if (bus.o_pix_valid === 1'b1)
      pq.push_back('{x: bus.o_pix_x, y: bus.o_pix_y, d: bus.o_pix_data, fd: bus.o_frame_done});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pix(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] d, input logic fd);
    pix_t p;
    p = '{x: 'x, y: 'x, d: 'x, fd: 1'bx};
    if (pq.size() > 0) p = pq.pop_front();
    check(tag, {15'd0, p.fd, p.x, p.y, p.d}, {15'd0, fd, x, y, d});
  endtask

  // Sends the top n bits of b, MSB first; sclk stays low/high four i_clk cycles each.
  task automatic spi_bits(input logic dc, input logic [7:0] b, input int n);
    bus.i_dc = dc;
    for (int i = 7; i > 7 - n; i--) begin
      bus.i_mosi = b[i];
      repeat (4) @(negedge i_clk);
      bus.i_sclk = 1'b1;
      rise_cyc = cyc;
      repeat (4) @(negedge i_clk);
      bus.i_sclk = 1'b0;
    end
    repeat (2) @(negedge i_clk);
  endtask

  task automatic cmd(input logic [7:0] b);
    spi_bits(1'b0, b, 8);
  endtask

  task automatic dat(input logic [7:0] b);
    spi_bits(1'b1, b, 8);
  endtask

  task automatic dat4(input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    dat(b0); dat(b1); dat(b2); dat(b3);
  endtask

  task automatic cs_low();
    bus.i_cs = 1'b0;
    repeat (4) @(negedge i_clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge i_clk);
    bus.i_cs = 1'b1;
    repeat (4) @(negedge i_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".cmd_valid"},  bus.o_cmd_valid, 0);
    check({tag, ".cmd"},        bus.o_cmd, 0);
    check({tag, ".xs"},         bus.o_xs, 0);
    check({tag, ".xe"},         bus.o_xe, 239);
    check({tag, ".ys"},         bus.o_ys, 0);
    check({tag, ".ye"},         bus.o_ye, 319);
    check({tag, ".pix_valid"},  bus.o_pix_valid, 0);
    check({tag, ".pix_x"},      bus.o_pix_x, 0);
    check({tag, ".pix_y"},      bus.o_pix_y, 0);
    check({tag, ".pix_data"},   bus.o_pix_data, 0);
    check({tag, ".frame_done"}, bus.o_frame_done, 0);
    check({tag, ".err"},        bus.o_err, 0);
  endtask

  int cnt0;

  initial begin
    i_rst = 1'b1;
    bus.i_sclk = 1'b0;
    bus.i_mosi = 1'b0;
    bus.i_dc   = 1'b0;
    bus.i_cs   = 1'b1;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("rst");
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);

    // Column window 70..170 commits only on the fourth data byte
    cs_low();
    cmd(8'h2A);
    check("caset.cmd_cnt", cmd_cnt, 1);
    check("caset.cmd", bus.o_cmd, 8'h2A);
    check("caset.latency", cmd_cyc - rise_cyc, 4);
    dat(8'h00); dat(8'h46); dat(8'h00);
    check("caset.xs_early", bus.o_xs, 0);
    check("caset.xe_early", bus.o_xe, 239);
    dat(8'hAA);
    check("caset.xs", bus.o_xs, 70);
    check("caset.xe", bus.o_xe, 170);
    check("caset.cmd_once", cmd_cnt, 1);

    // Page 110..110, then two pixels
    cmd(8'h2B);
    dat4(8'h00, 8'h6E, 8'h00, 8'h6E);
    check("paset.ys", bus.o_ys, 110);
    check("paset.ye", bus.o_ye, 110);
    cmd(8'h2C);
    dat(8'hFF); dat(8'hFF); dat(8'hF8); dat(8'h00);
    expect_pix("px0", 16'd70, 16'd110, 16'hFFFF, 1'b0);
    expect_pix("px1", 16'd71, 16'd110, 16'hF800, 1'b0);
    check("px.drain1", pq.size(), 0);

    // 2x2 window, five pixels: frame done on (1,1), wrap to (0,0)
    cmd(8'h2A); dat4(8'h00, 8'h00, 8'h00, 8'h01);
    cmd(8'h2B); dat4(8'h00, 8'h00, 8'h00, 8'h01);
    cmd(8'h2C);
    for (int i = 1; i <= 5; i++) begin
      dat(8'(i * 8'h11)); dat(8'(i * 8'h11));
    end
    expect_pix("frm0", 16'd0, 16'd0, 16'h1111, 1'b0);
    expect_pix("frm1", 16'd1, 16'd0, 16'h2222, 1'b0);
    expect_pix("frm2", 16'd0, 16'd1, 16'h3333, 1'b0);
    expect_pix("frm3", 16'd1, 16'd1, 16'h4444, 1'b1);
    expect_pix("frm4", 16'd0, 16'd0, 16'h5555, 1'b0);
    check("px.drain2", pq.size(), 0);

    // Partial byte discarded on deselect
    cs_high();
    cnt0 = cmd_cnt;
    cs_low();
    spi_bits(1'b0, 8'hB5, 5);
    cs_high();
    cs_low();
    cmd(8'h2C);
    check("partial.cmd_cnt", cmd_cnt, cnt0 + 1);
    check("partial.cmd", bus.o_cmd, 8'h2C);
    dat(8'h12); dat(8'h34);
    expect_pix("partial.px", 16'd0, 16'd0, 16'h1234, 1'b0);

    // Extra args ignored; aborted CASET leaves window; IDLE data ignored
    cmd(8'h2A); dat4(8'h00, 8'h05, 8'h00, 8'h09); dat(8'h00); dat(8'h01);
    check("extra.xs", bus.o_xs, 5);
    check("extra.xe", bus.o_xe, 9);
    cmd(8'h2A); dat(8'h00); dat(8'h07);
    cmd(8'h00);
    check("abort.xs", bus.o_xs, 5);
    check("abort.xe", bus.o_xe, 9);
    dat(8'h12); dat(8'h34);
    check("idle.nopix", pq.size(), 0);

    // Reversed column window
    check("err.before", bus.o_err, 0);
    cmd(8'h2A); dat4(8'h00, 8'hAA, 8'h00, 8'h46);
    check("err.xs", bus.o_xs, 170);
    check("err.xe", bus.o_xe, 70);
    check("err.set", bus.o_err, ERR_EXP);
    cmd(8'h2A); dat4(8'h00, 8'h00, 8'h00, 8'h01);
    check("err.sticky", bus.o_err, ERR_EXP);

    // Cursor x wraps from 0xFFFF to 0
    cmd(8'h2A); dat4(8'hFF, 8'hFF, 8'h00, 8'h00);
    cmd(8'h2B); dat4(8'h00, 8'h00, 8'h00, 8'h05);
    cmd(8'h2C);
    dat(8'hAB); dat(8'hCD); dat(8'hAB); dat(8'hCD);
    expect_pix("wrap0", 16'hFFFF, 16'd0, 16'hABCD, 1'b0);
    expect_pix("wrap1", 16'd0, 16'd0, 16'hABCD, 1'b0);

    // Reset in the middle of RAMWR and mid-byte
    cmd(8'h2A); dat4(8'h00, 8'h03, 8'h00, 8'h04);
    cmd(8'h2B); dat4(8'h00, 8'h03, 8'h00, 8'h04);
    cmd(8'h2C);
    dat(8'h99);
    spi_bits(1'b1, 8'hA0, 3);
    i_rst = 1'b1;
    bus.i_cs = 1'b1;
    bus.i_sclk = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("rst2");
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    cs_low();
    cmd(8'h2C);
    dat(8'h5A); dat(8'hA5);
    expect_pix("rst2.px", 16'd0, 16'd0, 16'h5AA5, 1'b0);
    check("rst2.drain", pq.size(), 0);
    cs_high();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_display_rx.md
SPI_DISPLAY_RX -- requirements
Module: spi_display_rx

Interface
REQ-001 SHALL provide parameter WIDTH, default 240, panel columns; sets reset value of window X end.
REQ-002 SHALL provide parameter HEIGHT, default 320, panel rows; sets reset value of window Y end.
REQ-003 i_clk  input  1  system clock; all logic on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_sclk  input  1  SPI serial clock, asynchronous to i_clk; i_clk SHALL be at least 4x i_sclk frequency.
REQ-006 i_mosi  input  1  SPI serial data, MSB first.
REQ-007 i_dc  input  1  0 = command byte, 1 = data byte.
REQ-008 i_cs  input  1  chip select, active-low.
REQ-009 o_cmd_valid  output  1  one-cycle pulse when a command byte is decoded.
REQ-010 o_cmd  output  8  last command byte.
REQ-011 o_xs / o_xe / o_ys / o_ye  output  16 each  committed column/page window.
REQ-012 o_pix_valid  output  1  one-cycle pulse per received pixel.
REQ-013 o_pix_x / o_pix_y  output  16 each  pixel address.
REQ-014 o_pix_data  output  16  RGB565 pixel value.
REQ-015 o_frame_done  output  1  one-cycle pulse when the last window pixel is written.
REQ-016 o_err  output  1  sticky window/bounds error flag.

Function
REQ-017 i_sclk, i_mosi, i_dc, i_cs SHALL each pass through a 2-FF synchronizer before use.
REQ-018 A bit SHALL be shifted in on each synchronized i_sclk rising edge while synchronized i_cs is low; i_dc SHALL be captured with the 8th bit.
REQ-019 i_cs deasserting with 1-7 bits received SHALL discard the partial byte and clear the bit counter; parser state SHALL be retained.
REQ-020 Decoded byte SHALL reach the parser exactly 3 i_clk cycles after the first i_clk edge sampling i_sclk high for the 8th bit; o_cmd_valid/o_pix_valid SHALL assert on that cycle.
REQ-021 Parser states: IDLE, CASET, PASET, RAMWR; any command byte SHALL abort the current state and pulse o_cmd_valid with o_cmd updated.
REQ-022 0x2A -> CASET, 0x2B -> PASET, 0x2C -> RAMWR, any other command -> IDLE; data bytes in IDLE ignored.
REQ-023 CASET: data bytes b0..b3 SHALL commit o_xs={b0,b1}, o_xe={b2,b3} on receipt of b3 only; bytes after b3 ignored; abort before b3 leaves window unchanged.
REQ-024 PASET: same as REQ-023 for o_ys/o_ye.
REQ-025 RAMWR entry SHALL set cursor x=o_xs, y=o_ys and clear the byte-pair phase.
REQ-026 RAMWR data bytes SHALL pair high-then-low into o_pix_data; second byte SHALL pulse o_pix_valid with current cursor on o_pix_x/o_pix_y.
REQ-027 After each pixel: x==o_xe -> x=o_xs, y+1; else x+1.
REQ-028 Pixel at x==o_xe and y==o_ye SHALL pulse o_frame_done in the same cycle as o_pix_valid and wrap cursor to (o_xs, o_ys).
REQ-029 A window commit during RAMWR is not possible (command aborts RAMWR); cursor SHALL only reload on RAMWR entry.
REQ-030 Arithmetic SHALL be 16-bit unsigned; cursor increment beyond 0xFFFF wraps to 0.

Reset
REQ-031 On i_rst: all pulses, o_cmd, o_pix_x/y/data, o_err = 0; o_xs=0, o_xe=WIDTH-1, o_ys=0, o_ye=HEIGHT-1; state IDLE; bit counter 0; synchronizers cleared (i_cs sync to 1).
REQ-032 Reset mid-byte or mid-RAMWR SHALL discard all partial data; first byte after release SHALL decode normally.

Configuration
REQ-033 Macro DISP_RX_BOUNDS_CHECK_EN defined: o_err SHALL set when a committed window has xs>xe or ys>ye, or xe>=WIDTH or ye>=HEIGHT, and stays set until reset.
REQ-034 Macro undefined: o_err SHALL be constant 0 and no check logic is built; all other behaviour identical.

Verification
REQ-035 Cmd 0x2A, data 00 46 00 AA -> o_cmd_valid once, o_cmd=0x2A, o_xs=70, o_xe=170 after 4th byte, not before.
REQ-036 Cmd 0x2B, data 00 6E 00 6E, cmd 0x2C, data FF FF F8 00 -> pixels (70,110)=0xFFFF, (71,110)=0xF800.
REQ-037 Window 0..1 x 0..1, RAMWR 5 pixels -> o_frame_done with 4th pixel (1,1); 5th pixel at (0,0).
REQ-038 CS low, 5 bits, CS high, then full byte 0x2C with dc=0 -> single o_cmd_valid, o_cmd=0x2C.
REQ-039 With DISP_RX_BOUNDS_CHECK_EN: CASET 00 AA 00 46 -> o_err=1 and stays 1 through subsequent valid CASET; without macro o_err=0.
REQ-040 Assert i_rst during RAMWR after 1 pixel byte -> all outputs at reset values; following RAMWR first pixel at (0,0).
